satd_row_sequencer: RTL
=======================

// Module: satd_row_sequencer
// PURPOSE
//  Sequences one 8-row block of ORG/CUR pixel rows into the differences datapath.
//  On start: generates row read addresses to the pixel row buffer and captures the
//  read data (fixed 1-cycle latency) into a 3-entry output queue.
//  Presents rows, tagged first/last/index, to the differences stage under a
//  valid/ready handshake, then pulses done. Sits between the row buffer and the
//  differences -> Hadamard -> SATD accumulation chain.
// PARAMETERS
//  WIDTH       8   bits per pixel
//  NUM_INPUTS  8   pixels per row (= row width of differences datapath)
//  ROWS        8   rows per block
//  ADDR_W      10  row-buffer row address width
// PORTS
//  clk        in   1                 clock, rising edge
//  rst        in   1                 reset, asynchronous, active-high
//  start      in   1                 begin a block; sampled only in IDLE
//  blk_base   in   ADDR_W            row address of block row 0; latched on accepted start
//  rd_en      out  1                 row-buffer read strobe
//  rd_addr    out  ADDR_W            row-buffer read address
//  rd_org     in   WIDTH*NUM_INPUTS  ORG row data, valid the cycle after rd_en
//  rd_cur     in   WIDTH*NUM_INPUTS  CUR row data, valid the cycle after rd_en
//  org_row    out  WIDTH*NUM_INPUTS  ORG row to differences (queue head)
//  cur_row    out  WIDTH*NUM_INPUTS  CUR row to differences (queue head)
//  row_valid  out  1                 queue head valid
//  row_ready  in   1                 downstream accepts head when row_valid&row_ready
//  row_idx    out  $clog2(ROWS)      index of head row, 0..ROWS-1
//  first_row  out  1                 head is row 0
//  last_row   out  1                 head is row ROWS-1
//  busy       out  1                 state != IDLE
//  done       out  1                 one-cycle pulse, block complete
// BEHAVIOUR
//  Reset: state IDLE, all counters 0, queue empty, in-flight flag 0.
//   rd_en, row_valid, busy and done are 0. rd_addr, org_row, cur_row, row_idx,
//   first_row and last_row are 0.
//  FSM IDLE -> ISSUE when start=1. Latch blk_base; issue_cnt=0.
//   start is ignored in every other state.
//  ISSUE: rd_en = (occ + inflight < 3), using registered counts only.
//   No combinational path from row_ready to rd_en.
//   rd_addr = blk_base + issue_cnt, modulo 2^ADDR_W (wraps silently).
//   issue_cnt increments on each rd_en. Leave to DRAIN after issuing row ROWS-1.
//  DRAIN: rd_en=0. Move to DONE on the handshake of last_row.
//  DONE: done=1 for one cycle, then IDLE.
//  Data capture: inflight is set on rd_en. On the next cycle rd_org/rd_cur are
//   pushed with their row index. Push and pop in the same cycle leave occ unchanged.
//  Queue never overflows (guaranteed by credit rule). Head outputs hold stable while
//   row_valid & !row_ready.
//  Latency, row_ready=1 throughout, start in cycle 0:
//   rd_en in cycles 1..8, row_valid in cycles 3..10 (one row per cycle).
//   done in cycle 11; busy=1 in cycles 1..11.
//  Async reset mid-block: queue flushed, FSM to IDLE. Read data returning in the
//   cycle after reset deassert is discarded (inflight cleared).
// STRUCTURE
//  satd_pkg: WIDTH/NUM_INPUTS/ROWS defaults, queue depth constant (3),
//   state enum {IDLE, ISSUE, DRAIN, DONE}. Shared with differences/Hadamard blocks.
//  Sub-module satd_row_queue: 3-entry FIFO of {row_idx, org, cur}.
//   Ports push/pop/occ/head; async reset.
//  Top: FSM, issue counter, address adder, inflight flag, credit compare.
// TESTING
//  1 Reset: assert rst mid-cycle -> rd_en, row_valid, busy, done = 0 immediately.
//  2 Nominal: blk_base=0x010, row_ready=1.
//    -> rd_addr 0x010..0x017 in cycles 1..8.
//    -> rows 0..7 in cycles 3..10 with first_row@3, last_row@10.
//    -> done@11.
//  3 Stall: row_ready=0 in cycles 3..7.
//    -> rd_en stops after 3 outstanding rows (addresses 0x010..0x012).
//    -> row 0 data held stable; resumes in order with no loss or duplication.
//    -> done 5 cycles later than nominal.
//  4 Wrap: blk_base=0x3FC (ADDR_W=10) -> rd_addr 0x3FC..0x3FF, 0x000..0x003.
//  5 Start while busy: pulse start in cycle 5 with blk_base=0x100
//    -> ignored, addresses unchanged, exactly 8 rows, one done.
//  6 Reset mid-block after row 4 handshake.
//    -> IDLE, queue empty, stale return data dropped.
//    -> new start gives a full 8 rows from the new base.

Source files
------------

// File: rtl/satd_pkg.sv
// Shared constants and types for the SATD row/differences/Hadamard chain.
// Holds datapath defaults, the row queue depth and the sequencer state encoding.
package satd_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_NUM_INPUTS = 8;
  localparam int DEF_ROWS       = 8;
  localparam int DEF_ADDR_W     = 10;
  localparam int QUEUE_DEPTH    = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } seq_state_t;

  // Queue pointers count modulo QUEUE_DEPTH, which is not a power of two.
  function automatic logic [1:0] qptr_next(input logic [1:0] ptr);
    return (ptr == 2'(QUEUE_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
  endfunction

endpackage

// File: rtl/satd_row_queue.sv
// Small FIFO holding captured {row index, ORG row, CUR row} entries.
// The head entry is presented directly; it only changes when popped.
module satd_row_queue
  import satd_pkg::*;
#(
  parameter int DATA_W = DEF_WIDTH * DEF_NUM_INPUTS,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [IDX_W-1:0]  push_idx,
  input  logic [DATA_W-1:0] push_org,
  input  logic [DATA_W-1:0] push_cur,
  input  logic              pop,
  output logic [1:0]        occ,
  output logic [IDX_W-1:0]  head_idx,
  output logic [DATA_W-1:0] head_org,
  output logic [DATA_W-1:0] head_cur
);

  logic [IDX_W-1:0]  idx_mem [QUEUE_DEPTH];
  logic [DATA_W-1:0] org_mem [QUEUE_DEPTH];
  logic [DATA_W-1:0] cur_mem [QUEUE_DEPTH];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic              pop_ok;

  assign pop_ok   = pop && (occ != 2'd0);
  assign head_idx = idx_mem[rd_ptr];
  assign head_org = org_mem[rd_ptr];
  assign head_cur = cur_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: storage is reset because the head is visible on the outputs and must read 0 out of reset; it is only three entries.
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        idx_mem[i] <= '0;
        org_mem[i] <= '0;
        cur_mem[i] <= '0;
      end
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        idx_mem[wr_ptr] <= push_idx;
        org_mem[wr_ptr] <= push_org;
        cur_mem[wr_ptr] <= push_cur;
        wr_ptr          <= qptr_next(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= qptr_next(rd_ptr);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      unique case ({push, pop_ok})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/satd_row_sequencer.sv
// Reads one block of ORG/CUR rows from the row buffer and streams them, tagged
// with index/first/last, to the differences stage under valid/ready.
module satd_row_sequencer
  import satd_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int NUM_INPUTS = DEF_NUM_INPUTS,
  parameter int ROWS       = DEF_ROWS,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             blk_base,
  output logic                          rd_en,
  output logic [ADDR_W-1:0]             rd_addr,
  input  logic [WIDTH*NUM_INPUTS-1:0]   rd_org,
  input  logic [WIDTH*NUM_INPUTS-1:0]   rd_cur,
  output logic [WIDTH*NUM_INPUTS-1:0]   org_row,
  output logic [WIDTH*NUM_INPUTS-1:0]   cur_row,
  output logic                          row_valid,
  input  logic                          row_ready,
  output logic [$clog2(ROWS)-1:0]       row_idx,
  output logic                          first_row,
  output logic                          last_row,
  output logic                          busy,
  output logic                          done
);

  localparam int ROW_W = WIDTH * NUM_INPUTS;
  localparam int IDX_W = $clog2(ROWS);

  seq_state_t        state;
  logic [ADDR_W-1:0] base_q;
  logic [IDX_W-1:0]  issue_cnt;
  logic [IDX_W-1:0]  inflight_idx;
  logic              inflight;
  logic [1:0]        occ;
  logic              pop;

  // Credit check uses registered counts only, so row_ready never reaches rd_en.
  assign rd_en     = (state == ISSUE) &&
                     ((3'(occ) + 3'(inflight)) < 3'(QUEUE_DEPTH));
  assign rd_addr   = base_q + ADDR_W'(issue_cnt);
  assign row_valid = (occ != 2'd0);
  assign pop       = row_valid && row_ready;
  assign first_row = row_valid && (row_idx == '0);
  assign last_row  = row_valid && (row_idx == IDX_W'(ROWS - 1));
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      base_q       <= '0;
      issue_cnt    <= '0;
      inflight     <= 1'b0;
      inflight_idx <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      inflight <= rd_en;
      if (rd_en) begin
        inflight_idx <= issue_cnt;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= ISSUE;
            base_q    <= blk_base;
            issue_cnt <= '0;
          end
        end
        ISSUE: begin
          if (rd_en) begin
            issue_cnt <= issue_cnt + 1'b1;
            if (issue_cnt == IDX_W'(ROWS - 1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && last_row) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read data returns one cycle after rd_en; inflight marks that cycle.
  satd_row_queue #(
    .DATA_W (ROW_W),
    .IDX_W  (IDX_W)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_idx (inflight_idx),
    .push_org (rd_org),
    .push_cur (rd_cur),
    .pop      (pop),
    .occ      (occ),
    .head_idx (row_idx),
    .head_org (org_row),
    .head_cur (cur_row)
  );

endmodule
